mc_controller: RTL and testbench

Multi-cycle control unit for the next-generation RV32I core. It replaces the single-cycle combinational controller with a registered FSM that sequences fetch, decode, execute, memory and writeback over several cycles. It talks to a shared instruction/data memory through a req/ready handshake with a parametrised timeout, and keeps a retired-instruction counter. It sits between the instruction register/flags of the multi-cycle datapath and that datapath's enables and muxes.

---
 rtl/mc_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_mc_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback, one state per cycle.
// Memory states hold on mem_req until mem_ready; a bounded wait escalates to a sticky FAULT.
module mc_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             ALUbit31,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ImmSrc,
    output logic             fault,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_FAULT    = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
    logic               retire_c, br_taken;

    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic use_sub);
        case (f3)
            3'b000:  return use_sub ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    always_comb begin
        case (funct3)
            3'b000:  br_taken = Zero;
            3'b001:  br_taken = !Zero;
            3'b100:  br_taken = ALUbit31;
            3'b101:  br_taken = !ALUbit31;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_B:    ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        req_c       = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        retire_c    = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUControl  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                req_c     = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW, OP_JALR: state_d = S_MEMADR;
                    OP_R:                  state_d = S_EXECR;
                    OP_I:                  state_d = S_EXECI;
                    OP_B:                  state_d = S_BRANCH;
                    OP_JAL:                state_d = S_JAL;
                    default:               state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW:   state_d = S_MEMREAD;
                    OP_SW:   state_d = S_MEMWRITE;
                    OP_JALR: state_d = S_JALR;
                    default: state_d = S_FAULT;
                endcase
            end
            S_MEMREAD: begin
                req_c  = 1'b1;
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                req_c       = 1'b1;
                mem_write_c = 1'b1;
                AdrSrc      = 1'b1;
                if (mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec(funct3, funct7b5);
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec(funct3, 1'b0);
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                pc_write_c = br_taken;
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            // Jumps: PC takes the target already in ALUOut while ALUOut captures OldPC+4 for rd.
            S_JAL, S_JALR: begin
                pc_write_c = 1'b1;
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                state_d    = S_ALUWB;
            end
            default: state_d = S_FAULT;
        endcase

        // A ready on the last allowed cycle is honoured above; only a miss escalates.
        if (req_c && !mem_ready && (wait_q == WAIT_LAST)) state_d = S_FAULT;

        if (state_d != state_q)        wait_d = '0;
        else if (req_c && !mem_ready)  wait_d = wait_q + 1'b1;
        else                           wait_d = wait_q;

        instret_d = retire_c ? instret_q + 1'b1 : instret_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    assign mem_req  = req_c       & ~reset;
    assign MemWrite = mem_write_c & ~reset;
    assign IRWrite  = ir_write_c  & ~reset;
    assign PCWrite  = pc_write_c  & ~reset;
    assign RegWrite = reg_write_c & ~reset;
    assign fault    = (state_q == S_FAULT);
    assign state    = state_q;
    assign instret  = instret_q;
endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: per-cycle expected outputs come from an instruction-step model and are scoreboarded.
module tb_mc_controller;
    localparam int MEM_TO = 4;
    localparam int CNT_W  = 4;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3, ST_MEMWB = 4,
                   ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7, ST_ALUWB = 8, ST_BRANCH = 9,
                   ST_JAL = 10, ST_JALR = 11, ST_FAULT = 12;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_JALR = 7'b1100111,
                           OP_R = 7'b0110011, OP_I = 7'b0010011, OP_B = 7'b1100011,
                           OP_JAL = 7'b1101111, OP_ILL = 7'b1111111;

    typedef struct packed {
        logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
        logic [1:0] result_src, src_a, src_b;
        logic [2:0] alu_ctl;
        logic [1:0] imm_src;
        logic       fault;
        logic [3:0] state;
        logic [3:0] instret;
    } obs_t;

    logic clk, reset, funct7b5, Zero, ALUbit31, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, fault;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;
    logic [CNT_W-1:0] instret;
    obs_t act;

    mc_controller #(.MEM_TIMEOUT(MEM_TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .ALUbit31(ALUbit31), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .fault(fault),
        .state(state), .instret(instret)
    );

    assign act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ALUControl, ImmSrc, fault, state, instret};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the current instruction is a list of steps; memory steps repeat until ready.
    int   plan[$];
    int   idx, waited, m_instret;
    bit   retired;
    int   zmode, bmode;
    obs_t exp_q[$];
    int   tests, fails;

    function automatic bit is_mem(input int s);
        return (s == ST_FETCH) || (s == ST_MEMREAD) || (s == ST_MEMWRITE);
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
        if (f3 == 3'd0) return sub ? 3'b001 : 3'b000;
        if (f3 == 3'd2) return 3'b101;
        if (f3 == 3'd6) return 3'b011;
        if (f3 == 3'd7) return 3'b010;
        return 3'b000;
    endfunction

    function automatic obs_t expect_out(input int s, input logic rst, input logic rdy);
        obs_t e;
        logic taken;
        e = '0;
        e.state   = 4'(s);
        e.instret = 4'(m_instret);
        e.imm_src = (op == OP_SW) ? 2'b01 : (op == OP_B) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
        case (funct3)
            3'd0: taken = Zero;
            3'd1: taken = !Zero;
            3'd4: taken = ALUbit31;
            3'd5: taken = !ALUbit31;
            default: taken = 1'b0;
        endcase
        case (s)
            ST_FETCH:    begin e.mem_req = 1; e.src_b = 2; e.result_src = 2; e.ir_write = rdy; e.pc_write = rdy; end
            ST_DECODE:   begin e.src_a = 1; e.src_b = 1; end
            ST_MEMADR:   begin e.src_a = 2; e.src_b = 1; end
            ST_MEMREAD:  begin e.mem_req = 1; e.adr_src = 1; end
            ST_MEMWB:    begin e.result_src = 1; e.reg_write = 1; end
            ST_MEMWRITE: begin e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; end
            ST_EXECR:    begin e.src_a = 2; e.alu_ctl = alu_of(funct3, funct7b5); end
            ST_EXECI:    begin e.src_a = 2; e.src_b = 1; e.alu_ctl = alu_of(funct3, 1'b0); end
            ST_ALUWB:    e.reg_write = 1;
            ST_BRANCH:   begin e.src_a = 2; e.alu_ctl = 3'b001; e.pc_write = taken; end
            ST_JAL, ST_JALR: begin e.pc_write = 1; e.src_a = 1; e.src_b = 2; end
            ST_FAULT:    e.fault = 1;
            default:     e.fault = 1;
        endcase
        if (rst) begin
            e.mem_req = 0; e.mem_write = 0; e.ir_write = 0; e.pc_write = 0; e.reg_write = 0;
        end
        return e;
    endfunction

    function automatic void advance(input int s, input logic rdy);
        retired = 0;
        if (s == ST_FAULT) return;
        if (is_mem(s) && !rdy) begin
            waited++;
            if (waited == MEM_TO) begin
                plan.delete();
                plan.push_back(ST_FAULT);
                idx = 0;
                waited = 0;
            end
            return;
        end
        waited = 0;
        if (idx == plan.size() - 1) begin
            m_instret = (m_instret + 1) % (1 << CNT_W);
            retired = 1;
            idx = 0;
        end else begin
            idx++;
        end
    endfunction

    task automatic do_cycle(input logic rst, input logic rdy, input bit chk);
        int s;
        reset     = rst;
        mem_ready = rdy;
        Zero      = (zmode == 2) ? 1'($urandom) : 1'(zmode);
        ALUbit31  = (bmode == 2) ? 1'($urandom) : 1'(bmode);
        s = plan[idx];
        if (chk) exp_q.push_back(expect_out(s, rst, rdy));
        if (rst) begin
            plan.delete();
            plan.push_back(ST_FETCH);
            idx = 0; waited = 0; m_instret = 0; retired = 0;
        end else begin
            advance(s, rdy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int dly, input int zm, input int bm);
        int s;
        logic rdy;
        op = o; funct3 = f3; funct7b5 = f7; zmode = zm; bmode = bm;
        plan.delete();
        plan.push_back(ST_FETCH);
        plan.push_back(ST_DECODE);
        case (o)
            OP_LW:   begin plan.push_back(ST_MEMADR); plan.push_back(ST_MEMREAD); plan.push_back(ST_MEMWB); end
            OP_SW:   begin plan.push_back(ST_MEMADR); plan.push_back(ST_MEMWRITE); end
            OP_JALR: begin plan.push_back(ST_MEMADR); plan.push_back(ST_JALR); plan.push_back(ST_ALUWB); end
            OP_R:    begin plan.push_back(ST_EXECR); plan.push_back(ST_ALUWB); end
            OP_I:    begin plan.push_back(ST_EXECI); plan.push_back(ST_ALUWB); end
            OP_B:    plan.push_back(ST_BRANCH);
            OP_JAL:  begin plan.push_back(ST_JAL); plan.push_back(ST_ALUWB); end
            default: plan.push_back(ST_FAULT);
        endcase
        idx = 0;
        waited = 0;
        for (int n = 0; n < 40; n++) begin
            s = plan[idx];
            rdy = is_mem(s) ? (waited >= dly) : 1'($urandom);
            do_cycle(1'b0, rdy, 1'b1);
            if (retired) break;
            if (plan[idx] == ST_FAULT) begin
                for (int k = 0; k < 3; k++) do_cycle(1'b0, 1'($urandom), 1'b1);
                do_cycle(1'b1, 1'b0, 1'b1);
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL cycle_check #%0d: state got %0d want %0d, instret got %0d want %0d, outputs got %h want %h",
                         tests, act.state, e.state, act.instret, e.instret, act, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        logic [6:0] ops[7];
        int r, dly;
        ops = '{OP_LW, OP_SW, OP_JALR, OP_R, OP_I, OP_B, OP_JAL};
        tests = 0; fails = 0;
        op = OP_R; funct3 = 3'd0; funct7b5 = 1'b0; zmode = 0; bmode = 0;
        plan.push_back(ST_FETCH);
        idx = 0; waited = 0; m_instret = 0; retired = 0;
        do_cycle(1'b1, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b1);

        run_instr(OP_R, 3'd0, 1'b0, 0, 2, 2);
        run_instr(OP_R, 3'd0, 1'b1, 0, 2, 2);
        run_instr(OP_LW, 3'd2, 1'b0, 3, 2, 2);
        run_instr(OP_B, 3'd0, 1'b0, 0, 1, 2);
        run_instr(OP_B, 3'd1, 1'b0, 0, 1, 2);
        run_instr(OP_B, 3'd4, 1'b0, 0, 2, 1);
        run_instr(OP_SW, 3'd2, 1'b0, 2, 2, 2);
        run_instr(OP_JAL, 3'd0, 1'b0, 0, 2, 2);
        run_instr(OP_JALR, 3'd0, 1'b0, 1, 2, 2);
        run_instr(OP_I, 3'd7, 1'b1, 0, 2, 2);
        run_instr(OP_R, 3'd0, 1'b0, MEM_TO, 2, 2);
        run_instr(OP_R, 3'd0, 1'b0, MEM_TO - 1, 2, 2);
        run_instr(OP_ILL, 3'd0, 1'b0, 0, 2, 2);
        for (int i = 0; i < 17; i++) run_instr(OP_R, 3'($urandom), 1'($urandom), 0, 2, 2);

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom % 16);
            dly = (r < 9) ? 0 : (r < 14) ? int'($urandom % MEM_TO) : MEM_TO;
            if ($urandom % 20 == 0)
                run_instr(7'($urandom), 3'($urandom), 1'($urandom), dly, 2, 2);
            else
                run_instr(ops[$urandom % 7], 3'($urandom), 1'($urandom), dly, 2, 2);
        end

        repeat (2) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
